// File: rtl/led_meter_pkg.sv
// Shared constants and FSM encoding for the LED PWM duty meter.
package led_meter_pkg;

    localparam int unsigned NUM_CH         = 4;
    localparam int unsigned CNT_WIDTH_DEF  = 20;
    localparam int unsigned PERIOD_MAX_DEF = 1000000;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_MEASURE = 2'd1;
    localparam state_t ST_STUCK   = 2'd2;

endpackage

// File: rtl/led_duty_chan.sv
// One channel of the duty meter: synchronizer, rise detect, period/high counters,
// latched result and a one-cycle valid strobe per new result.
module led_duty_chan
    import led_meter_pkg::*;
#(
    parameter int unsigned cnt_width  = CNT_WIDTH_DEF,
    parameter int unsigned period_max = PERIOD_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 led,
    output logic                 valid,
    output logic [cnt_width-1:0] period,
    output logic [cnt_width-1:0] high,
    output logic                 stuck
);

    localparam logic [cnt_width-1:0] PMAX = cnt_width'(period_max);
    localparam logic [cnt_width-1:0] ONE  = cnt_width'(1);

    logic                 sync_q1;
    logic                 sync;
    logic                 sync_d;
    logic                 rise_c;

    state_t               state;
    state_t               state_nxt;
    logic [cnt_width-1:0] cnt;
    logic [cnt_width-1:0] cnt_nxt;
    logic [cnt_width-1:0] hcnt;
    logic [cnt_width-1:0] hcnt_nxt;
    logic [cnt_width-1:0] period_nxt;
    logic [cnt_width-1:0] high_nxt;
    logic                 stuck_nxt;
    logic                 valid_nxt;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync    <= 1'b0;
            sync_d  <= 1'b0;
        end else begin
            sync_q1 <= led;
            sync    <= sync_q1;
            sync_d  <= sync;
        end
    end

    assign rise_c = sync & ~sync_d;

    // Next-state, counter and result logic; a rise always beats the timeout.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        hcnt_nxt   = hcnt;
        period_nxt = period;
        high_nxt   = high;
        stuck_nxt  = stuck;
        valid_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rise_c) begin
                    state_nxt = ST_MEASURE;
                    cnt_nxt   = ONE;
                    hcnt_nxt  = ONE;
                end else if (cnt == PMAX) begin
                    state_nxt  = ST_STUCK;
                    period_nxt = '0;
                    high_nxt   = sync ? PMAX : '0;
                    stuck_nxt  = 1'b1;
                    valid_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            ST_MEASURE: begin
                if (rise_c) begin
                    period_nxt = cnt;
                    high_nxt   = hcnt;
                    valid_nxt  = 1'b1;
                    cnt_nxt    = ONE;
                    hcnt_nxt   = ONE;
                end else if (cnt == PMAX) begin
                    state_nxt  = ST_STUCK;
                    period_nxt = '0;
                    high_nxt   = sync ? PMAX : '0;
                    stuck_nxt  = 1'b1;
                    valid_nxt  = 1'b1;
                end else begin
                    cnt_nxt  = cnt + ONE;
                    hcnt_nxt = hcnt + cnt_width'(sync);
                end
            end
            ST_STUCK: begin
                if (rise_c) begin
                    state_nxt = ST_MEASURE;
                    cnt_nxt   = ONE;
                    hcnt_nxt  = ONE;
                    stuck_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters and latched results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            hcnt   <= '0;
            period <= '0;
            high   <= '0;
            stuck  <= 1'b0;
            valid  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            hcnt   <= hcnt_nxt;
            period <= period_nxt;
            high   <= high_nxt;
            stuck  <= stuck_nxt;
            valid  <= valid_nxt;
        end
    end

endmodule

// File: rtl/led_duty_meter.sv
// Four-channel LED PWM period/high-time meter with registered readback.
module led_duty_meter
    import led_meter_pkg::*;
#(
    parameter int unsigned cnt_width  = CNT_WIDTH_DEF,
    parameter int unsigned period_max = PERIOD_MAX_DEF
) (
    input  logic                 clk_out,
    input  logic                 rst,
    input  logic [3:0]           led,
    input  logic [1:0]           rd_sel,
    output logic [3:0]           meas_valid,
    output logic [cnt_width-1:0] rd_period,
    output logic [cnt_width-1:0] rd_high,
    output logic                 rd_stuck
);

    logic [cnt_width-1:0] ch_period [NUM_CH];
    logic [cnt_width-1:0] ch_high   [NUM_CH];
    logic [NUM_CH-1:0]    ch_stuck;
    logic [NUM_CH-1:0]    ch_valid;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        led_duty_chan #(
            .cnt_width  (cnt_width),
            .period_max (period_max)
        ) u_chan (
            .clk    (clk_out),
            .rst    (rst),
            .led    (led[g]),
            .valid  (ch_valid[g]),
            .period (ch_period[g]),
            .high   (ch_high[g]),
            .stuck  (ch_stuck[g])
        );
    end

    assign meas_valid = ch_valid;

    // Registered readback mux of the selected channel's latched result.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            rd_period <= '0;
            rd_high   <= '0;
            rd_stuck  <= 1'b0;
        end else begin
            rd_period <= ch_period[rd_sel];
            rd_high   <= ch_high[rd_sel];
            rd_stuck  <= ch_stuck[rd_sel];
        end
    end

endmodule

// File: tb/tb_led_duty_meter.sv
// Scoreboard bench for led_duty_meter: pin-level edge tracking predicts each result.
module tb_led_duty_meter;

    localparam int unsigned CW   = 20;
    localparam int unsigned PMAX = 100;

    typedef struct {
        int cyc;
        int period;
        int high;
        bit stuck;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    led = 4'd0;
    logic [1:0]    rd_sel = 2'd0;
    logic [3:0]    meas_valid;
    logic [CW-1:0] rd_period;
    logic [CW-1:0] rd_high;
    logic          rd_stuck;

    led_duty_meter #(
        .cnt_width  (CW),
        .period_max (PMAX)
    ) dut (
        .clk_out    (clk),
        .rst        (rst),
        .led        (led),
        .rd_sel     (rd_sel),
        .meas_valid (meas_valid),
        .rd_period  (rd_period),
        .rd_high    (rd_high),
        .rd_stuck   (rd_stuck)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t sb [4][$];
    logic [3:0] mask = 4'd0;
    bit   pend_v = 1'b0;
    exp_t pend_e;
    exp_t mon_e;

    // Pin-level wave generator and edge model state
    bit en    [4];
    bit man   [4];
    bit prev  [4];
    bit armed [4];
    int per_p [4];
    int hi_p  [4];
    int ph    [4];
    int last_rise [4];
    int hcnt_b [4];
    int rel = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            en[i] = 0; man[i] = 0; prev[i] = 0; armed[i] = 0;
            ph[i] = 0; last_rise[i] = 0; hcnt_b[i] = 0;
            sb[i].delete();
        end
        led = 4'd0;
    endtask

    // Advance one clock and drive the next pin levels; expected results are queued here.
    task automatic step();
        logic [3:0] v;
        bit   lvl;
        exp_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) begin
                lvl   = (ph[i] < hi_p[i]);
                ph[i] = (ph[i] + 1 == per_p[i]) ? 0 : ph[i] + 1;
            end else begin
                lvl = man[i];
            end
            if (lvl && !prev[i]) begin
                if (armed[i]) begin
                    e.cyc = cyc + 3; e.period = cyc - last_rise[i];
                    e.high = hcnt_b[i]; e.stuck = 1'b0;
                    sb[i].push_back(e);
                end
                armed[i] = 1; last_rise[i] = cyc; hcnt_b[i] = 1;
            end else if (lvl) begin
                hcnt_b[i]++;
            end
            prev[i] = lvl;
            v[i] = lvl;
        end
        led = v;
    endtask

    task automatic do_reset();
        mask = 4'd0;
        pend_v = 1'b0;
        clear_model();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rel = cyc;
    endtask

    task automatic drain_and_check(input string tag);
        for (int i = 0; i < 4; i++) en[i] = 0;
        for (int i = 0; i < 4; i++) man[i] = 0;
        repeat (6) step();
        check(tag, longint'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()), 0);
    endtask

    // Output monitor: pop expectations on valid pulses, then check readback one cycle later.
    always @(negedge clk) begin
        if (pend_v) begin
            pend_v = 1'b0;
            check("rd_period", longint'(rd_period), longint'(pend_e.period));
            check("rd_high",   longint'(rd_high),   longint'(pend_e.high));
            check("rd_stuck",  longint'(rd_stuck),  longint'(pend_e.stuck));
        end
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                while (sb[i].size() > 0 && sb[i][0].cyc < cyc) begin
                    mon_e = sb[i].pop_front();
                    check($sformatf("ch%0d_valid_late", i), longint'(cyc), longint'(mon_e.cyc));
                end
                if (meas_valid[i]) begin
                    if (sb[i].size() == 0) begin
                        check($sformatf("ch%0d_valid_unexpected", i), longint'(meas_valid[i]), 0);
                    end else begin
                        mon_e = sb[i].pop_front();
                        check($sformatf("ch%0d_valid_cyc", i), longint'(cyc), longint'(mon_e.cyc));
                        if (rd_sel == 2'(i)) begin
                            pend_e = mon_e;
                            pend_v = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;

        // Reset held with toggling pins
        clear_model();
        rst = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1 led = 4'($urandom);
        end
        @(negedge clk);
        check("rst_valid",  longint'(meas_valid), 0);
        check("rst_period", longint'(rd_period), 0);
        check("rst_high",   longint'(rd_high), 0);
        check("rst_stuck",  longint'(rd_stuck), 0);
        do_reset();

        // Channel 0: 10 high / 30 low
        mask = 4'b0001; rd_sel = 2'd0;
        en[0] = 1; per_p[0] = 40; hi_p[0] = 10;
        repeat (170) step();

        // Asynchronous reset mid-measurement
        @(negedge clk);
        #2;
        mask = 4'd0; pend_v = 1'b0;
        clear_model();
        rst = 1'b1;
        #1;
        check("async_rst_valid",  longint'(meas_valid), 0);
        check("async_rst_period", longint'(rd_period), 0);
        check("async_rst_high",   longint'(rd_high), 0);
        check("async_rst_stuck",  longint'(rd_stuck), 0);
        do_reset();
        mask = 4'b0001; rd_sel = 2'd0;
        en[0] = 1; per_p[0] = 40; hi_p[0] = 10;
        repeat (90) step();
        drain_and_check("ch0_sb_empty");

        // Four independent channels
        do_reset();
        mask = 4'b1111; rd_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            en[i] = 1; per_p[i] = 20 * (i + 1); hi_p[i] = 5 * (i + 1);
        end
        repeat (300) step();
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            step();
            check($sformatf("sweep%0d_period", i), longint'(rd_period), longint'(per_p[i]));
            check($sformatf("sweep%0d_high", i),   longint'(rd_high),   longint'(hi_p[i]));
            check($sformatf("sweep%0d_stuck", i),  longint'(rd_stuck),  0);
        end
        repeat (20) step();
        drain_and_check("multi_sb_empty");

        // Channel 2 held high after one edge
        do_reset();
        mask = 4'b0100; rd_sel = 2'd2;
        step(); step();
        man[2] = 1;
        step();
        n = cyc;
        mon_e.cyc = n + 3 + PMAX; mon_e.period = 0; mon_e.high = PMAX; mon_e.stuck = 1'b1;
        sb[2].push_back(mon_e);
        armed[2] = 0;
        repeat (PMAX + 8) step();
        man[2] = 0;
        repeat (5) step();
        man[2] = 1;
        step();
        repeat (4) step();
        check("ch2_stuck_cleared", longint'(rd_stuck), 0);
        man[2] = 0;
        repeat (15) step();
        man[2] = 1;
        step();
        repeat (6) step();
        drain_and_check("ch2_sb_empty");

        // Channel 1 low from reset
        do_reset();
        mask = 4'b0010; rd_sel = 2'd1;
        mon_e.cyc = rel + PMAX + 1; mon_e.period = 0; mon_e.high = 0; mon_e.stuck = 1'b1;
        sb[1].push_back(mon_e);
        repeat (PMAX + 20) step();
        drain_and_check("ch1_sb_empty");

        // Period exactly period_max on channel 3
        do_reset();
        mask = 4'b1000; rd_sel = 2'd3;
        en[3] = 1; per_p[3] = PMAX; hi_p[3] = 30;
        repeat (330) step();
        check("ch3_not_stuck", longint'(rd_stuck), 0);
        check("ch3_period_max", longint'(rd_period), longint'(PMAX));
        drain_and_check("ch3_sb_empty");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
